// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths, encodings and FSM states for the instruction-fetch stage.
//   IF_ADDR_W / IF_DATA_W : default address and instruction widths
//   IF_RESET_PC           : default first fetch address after reset
//   IF_NOP_INST           : default encoding shown on inst_o while valid_o=0
//   fetch_state_e         : S_BOOT / S_REQ / S_HOLD
package if_fetch_pkg;

    localparam int          IF_ADDR_W   = 16;
    localparam int          IF_DATA_W   = 16;
    localparam logic [15:0] IF_RESET_PC = 16'h0000;
    localparam logic [15:0] IF_NOP_INST = 16'h0800;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_hold_buf.sv
// if_hold_buf: one-entry skid register {valid, inst, pc} for a fetch accepted during a stall.
//   clk, rst     : clock, asynchronous active-low reset
//   load_i       : capture inst_i/pc_i and mark the entry valid
//   clear_i      : drop the entry
//   inst_i, pc_i : instruction and its sequential pc to capture
//   valid_o, inst_o, pc_o : current entry
module if_hold_buf
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = IF_ADDR_W,
    parameter int DATA_W = IF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = load_i ? 1'b1 : (clear_i ? 1'b0 : valid_q);
        inst_d  = load_i ? inst_i : inst_q;
        pc_d    = load_i ? pc_i : pc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage; owns the PC, runs a req/ack imem port and feeds IF/ID.
//   clk, rst                 : clock, asynchronous active-low reset
//   stall_i                  : freeze pc_o/inst_o/valid_o
//   branch_flag_i/addr_i     : redirect request from decode for the instruction on inst_o
//   imem_req_o/addr_o        : memory request, address stable until imem_ack_i
//   imem_ack_i/rdata_i       : one-cycle acknowledge with data
//   pc_o, inst_o, valid_o    : IF/ID outputs (pc_o is fetch address + 1)
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = IF_ADDR_W,
    parameter int                DATA_W   = IF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = IF_RESET_PC,
    parameter logic [DATA_W-1:0] NOP_INST = IF_NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic              valid_o
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] next_pc_q, next_pc_d;
    logic              squash_q, squash_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;

    logic              hb_load, hb_clear, hb_valid;
    logic [DATA_W-1:0] hb_inst;
    logic [ADDR_W-1:0] hb_pc;
    logic [ADDR_W-1:0] req_inc;
    logic              redirect;

    assign req_inc  = req_addr_q + ADDR_W'(1);
    // A stalled decode re-asserts its branch later, so only act on it when not stalled.
    assign redirect = branch_flag_i && valid_q && !stall_i;

    if_hold_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load_i  (hb_load),
        .clear_i (hb_clear),
        .inst_i  (imem_rdata_i),
        .pc_i    (req_inc),
        .valid_o (hb_valid),
        .inst_o  (hb_inst),
        .pc_o    (hb_pc)
    );

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        next_pc_d  = next_pc_q;
        squash_d   = squash_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        valid_d    = valid_q;
        hb_load    = 1'b0;
        hb_clear   = 1'b0;
        if (redirect) begin
            next_pc_d = branch_addr_i;
            valid_d   = 1'b0;
            inst_d    = NOP_INST;
            hb_clear  = 1'b1;
        end
        case (state_q)
            S_BOOT: begin
                state_d    = S_REQ;
                req_addr_d = next_pc_q;
            end
            S_REQ: begin
                if (!stall_i) begin
                    valid_d = 1'b0;
                    inst_d  = NOP_INST;
                end
                if (imem_ack_i) begin
                    squash_d = 1'b0;
                    // Wrong-path data: drop it and aim the next request at the redirect target.
                    if (squash_q || redirect) begin
                        req_addr_d = next_pc_d;
                    end else if (!stall_i) begin
                        inst_d     = imem_rdata_i;
                        pc_d       = req_inc;
                        valid_d    = 1'b1;
                        next_pc_d  = req_inc;
                        req_addr_d = req_inc;
                    end else begin
                        hb_load = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (redirect) begin
                    // Request already on the bus must complete; remember to discard it.
                    squash_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    state_d    = S_REQ;
                    hb_clear   = 1'b1;
                    req_addr_d = redirect ? branch_addr_i : hb_pc;
                    if (!redirect && hb_valid) begin
                        inst_d    = hb_inst;
                        pc_d      = hb_pc;
                        valid_d   = 1'b1;
                        next_pc_d = hb_pc;
                    end
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_BOOT;
            req_addr_q <= '0;
            next_pc_q  <= RESET_PC;
            squash_q   <= 1'b0;
            pc_q       <= '0;
            inst_q     <= NOP_INST;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            next_pc_q  <= next_pc_d;
            squash_q   <= squash_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_req_o  = (state_q == S_REQ);
    assign imem_addr_o = req_addr_q;
    assign pc_o        = pc_q;
    assign inst_o      = inst_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch with a stream-level reference model.
module tb_if_fetch;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        bflag;
    logic [15:0] baddr;
    logic        req;
    logic [15:0] addr;
    logic        ack;
    logic [15:0] rdata;
    logic [15:0] pc;
    logic [15:0] inst;
    logic        valid;

    logic [15:0] mem [0:65535];
    int          lat;
    int          wcnt;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_pc;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .branch_flag_i (bflag),
        .branch_addr_i (baddr),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_ack_i    (ack),
        .imem_rdata_i  (rdata),
        .pc_o          (pc),
        .inst_o        (inst),
        .valid_o       (valid)
    );

    // Memory: acknowledges after the request has waited lat cycles.
    assign ack   = req && (wcnt == lat);
    assign rdata = mem[addr];

    always @(posedge clk or negedge rst) begin
        if (!rst) wcnt <= 0;
        else if (!req || ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int i;
        i = 0;
        while (!valid && i < 40) begin
            @(negedge clk);
            i++;
        end
        check(name, 16'(valid), 16'h0001);
    endtask

    task automatic do_branch(input logic [15:0] target);
        wait_valid("branch_wait");
        bflag = 1'b1;
        baddr = target;
        @(negedge clk);
        bflag = 1'b0;
    endtask

    // Model: instructions appear in program order from exp_pc; a taken redirect
    // restarts the order at its target; a stall freezes the outputs.
    initial begin
        logic        p_rst, p_stall, p_flag, p_valid, p_req, p_ack;
        logic [15:0] p_baddr, p_pc, p_inst, p_addr;
        exp_pc = 16'h0000;
        forever begin
            @(posedge clk);
            p_rst = rst; p_stall = stall; p_flag = bflag; p_valid = valid;
            p_req = req; p_ack = ack; p_baddr = baddr; p_pc = pc; p_inst = inst; p_addr = addr;
            #1;
            if (!p_rst || !rst) begin
                exp_pc = 16'h0000;
            end else begin
                if (p_req && !p_ack) begin
                    check("hs_req_held", 16'(req), 16'h0001);
                    check("hs_addr_stable", addr, p_addr);
                end
                if (p_stall) begin
                    check("stall_valid", 16'(valid), 16'(p_valid));
                    check("stall_inst", inst, p_inst);
                    check("stall_pc", pc, p_pc);
                end else if (p_flag && p_valid) begin
                    check("redir_valid", 16'(valid), 16'h0000);
                    check("redir_inst", inst, NOP);
                    exp_pc = p_baddr;
                end else if (valid) begin
                    check("stream_inst", inst, mem[exp_pc]);
                    check("stream_pc", pc, exp_pc + 16'd1);
                    exp_pc = exp_pc + 16'd1;
                end else begin
                    check("bubble_inst", inst, NOP);
                end
            end
        end
    end

    initial begin
        logic [15:0] zw [4];
        logic [15:0] h_inst, h_addr;
        int          i;
        zw = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        rst = 1'b0; stall = 1'b0; bflag = 1'b0; baddr = '0; lat = 0;
        for (int k = 0; k < 65536; k++) mem[k] = 16'(k) ^ 16'h5A00;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        repeat (2) @(negedge clk);
        check("rst_req", 16'(req), 16'h0000);
        check("rst_addr", addr, 16'h0000);
        check("rst_pc", pc, 16'h0000);
        check("rst_inst", inst, 16'h0800);
        check("rst_valid", 16'(valid), 16'h0000);
        rst = 1'b1;
        // zero-wait: boot cycle, then one instruction per cycle
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("zw_inst", inst, zw[k]);
            check("zw_pc", pc, 16'(k + 1));
            check("zw_valid", 16'(valid), 16'h0001);
        end
        // wrap: fetch from 0xFFFF continues at 0x0000
        @(negedge clk);
        do_branch(16'hFFFF);
        wait_valid("wrap_wait");
        check("wrap_inst", inst, 16'hA5FF);
        check("wrap_pc", pc, 16'h0000);
        @(negedge clk);
        check("wrap_next_inst", inst, 16'h1111);
        check("wrap_next_pc", pc, 16'h0001);
        // two-cycle-latency memory
        rst = 1'b0; lat = 2;
        @(negedge clk);
        rst = 1'b1;
        wait_valid("lat_wait");
        check("lat_inst", inst, 16'h1111);
        check("lat_pc", pc, 16'h0001);
        // stall while an ack arrives
        stall = 1'b1;
        i = 0;
        while (!ack && i < 10) begin
            @(negedge clk);
            i++;
        end
        check("stall_ack_seen", 16'(ack), 16'h0001);
        h_inst = rdata; h_addr = addr;
        @(posedge clk); #1;
        check("hold_req_low", 16'(req), 16'h0000);
        check("hold_frozen_inst", inst, 16'h1111);
        @(negedge clk);
        @(negedge clk);
        stall = 1'b0;
        @(negedge clk);
        check("release_valid", 16'(valid), 16'h0001);
        check("release_inst", inst, h_inst);
        check("release_pc", pc, h_addr + 16'd1);
        @(negedge clk);
        check("lat_bubble_valid", 16'(valid), 16'h0000);
        check("lat_bubble_inst", inst, 16'h0800);
        // redirect while the request to 0x0005 is pending
        i = 0;
        while (!(req && !ack && valid && addr == 16'h0005) && i < 60) begin
            @(negedge clk);
            i++;
        end
        check("squash_setup_addr", addr, 16'h0005);
        bflag = 1'b1; baddr = 16'h0040;
        @(negedge clk);
        bflag = 1'b0;
        i = 0;
        while (!(req && addr == 16'h0040) && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("squash_next_addr", addr, 16'h0040);
        wait_valid("squash_wait");
        check("squash_inst", inst, 16'h5A40);
        check("squash_pc", pc, 16'h0041);
        // branch during stall is ignored, repeated after it is taken
        stall = 1'b1; bflag = 1'b1; baddr = 16'h0020;
        repeat (3) @(negedge clk);
        check("stallbr_inst", inst, 16'h5A40);
        stall = 1'b0;
        @(negedge clk);
        bflag = 1'b0;
        wait_valid("stallbr_wait");
        check("stallbr_inst_after", inst, 16'h5A20);
        check("stallbr_pc_after", pc, 16'h0021);
        // reset mid-request at 0x0010
        do_branch(16'h0010);
        i = 0;
        while (!(req && !ack && addr == 16'h0010) && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("midrst_setup_addr", addr, 16'h0010);
        rst = 1'b0;
        #1;
        check("midrst_req", 16'(req), 16'h0000);
        check("midrst_addr", addr, 16'h0000);
        check("midrst_pc", pc, 16'h0000);
        check("midrst_inst", inst, 16'h0800);
        check("midrst_valid", 16'(valid), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_valid("midrst_wait");
        check("midrst_refetch_inst", inst, 16'h1111);
        check("midrst_refetch_pc", pc, 16'h0001);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the 16-bit MIPS16-style pipeline; the producer end of the decode interface.
- Owns the PC and drives a request/acknowledge instruction-memory port.
- Presents pc_o/inst_o/valid_o to the IF/ID boundary.
- Consumes the decode stage's branch_flag/branch_addr redirect and the pipeline stall, squashing wrong-path fetches.

Parameters:
ADDR_W, 16, instruction address width
DATA_W, 16, instruction width
RESET_PC, 16'h0000, first fetch address after reset
NOP_INST, 16'h0800, encoding driven on inst_o when valid_o=0

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (rst==0 resets)
stall_i  in  1  pipeline stall; IF/ID outputs must hold
branch_flag_i  in  1  decode requests redirect for the instruction currently on inst_o
branch_addr_i  in  ADDR_W  redirect target
imem_req_o  out  1  memory request
imem_addr_o  out  ADDR_W  request address, stable while imem_req_o=1 until ack
imem_ack_i  in  1  one-cycle acknowledge; imem_rdata_i valid in the same cycle
imem_rdata_i  in  DATA_W  fetched instruction
pc_o  out  ADDR_W  fetch address of inst_o plus 1 (sequential PC used by decode)
inst_o  out  DATA_W  instruction to decode
valid_o  out  1  inst_o is a real instruction

Behaviour:
- Reset (rst=0, async):
  - Outputs: imem_req_o=0, imem_addr_o=0, pc_o=0, inst_o=NOP_INST, valid_o=0.
  - Internal: next_pc=RESET_PC, squash=0, hold buffer empty, state=S_BOOT.
- A reset mid-request abandons it; no ack is tracked afterwards.
- FSM states:
  - S_BOOT: one cycle after reset release, then S_REQ with req_addr=next_pc.
  - S_REQ: imem_req_o=1, imem_addr_o=req_addr.
  - S_HOLD: imem_req_o=0; one captured instruction waits in the hold buffer.
- Handshake:
  - req stays high and req_addr stays stable until imem_ack_i.
  - Ack may arrive in the first request cycle (zero-wait gives 1 instr/cycle).
  - After an ack, the next request is issued the following cycle.
- Accept (S_REQ, ack=1, squash=0, no redirect this cycle):
  - If stall_i=0: inst_o<=rdata, pc_o<=req_addr+1, valid_o<=1, next_pc<=req_addr+1, new req_addr<=req_addr+1.
  - If stall_i=1: capture {rdata, req_addr+1} in the hold buffer, go to S_HOLD, and leave the outputs untouched.
- No ack in S_REQ with stall_i=0: valid_o<=0, inst_o<=NOP_INST (bubble).
- stall_i=1: pc_o/inst_o/valid_o hold their values. branch_flag_i is ignored, because decode re-asserts it once the stall clears.
- S_HOLD with stall_i=0: buffer moves to the outputs, next request targets the buffer pc, state returns to S_REQ.
- Redirect: taken when branch_flag_i=1, valid_o=1 and stall_i=0. There is no delay slot.
  - next_pc<=branch_addr_i, valid_o<=0, inst_o<=NOP_INST.
  - The hold buffer is discarded.
  - Redirect with ack in the same cycle: rdata is discarded, and a request to branch_addr_i is issued next cycle.
  - Redirect while a request is pending without ack: set squash, keep imem_addr_o unchanged. The squashed ack's data is dropped and squash clears; the next request uses branch_addr_i.
  - Redirect in the cycle S_HOLD releases: the buffer is dropped, not presented.
  - A second redirect while squash=1 only overwrites next_pc.
- Arithmetic: PC increments modulo 2^ADDR_W; 16'hFFFF+1 wraps to 16'h0000 with no flag.

Decomposition:
- Shared defines (existing file): ADDR_W/DATA_W bus macros, NOP_INST, RstEnable-style polarity macro for active-low reset, FSM state encodings S_BOOT/S_REQ/S_HOLD.
- Optional sub-module if_hold_buf: one-entry skid register {valid, inst, pc} with load/clear.

Test Plan:
- Zero-wait memory, ack tied to req, mem[0..3]=1111,2222,3333,4444 -> from cycle 2 after reset inst_o=1111,2222,3333,4444 on consecutive cycles, pc_o=1,2,3,4, valid_o=1.
- Memory with 2-cycle latency -> each instruction is preceded by valid_o=0 bubbles with inst_o=0800; imem_addr_o stable while req is high.
- stall_i high for 3 cycles while an ack arrives -> outputs frozen; S_HOLD entered, imem_req_o=0; on release the held instruction appears, then fetch resumes at its pc.
- branch_flag_i=1, branch_addr_i=0x0040 while a request to 0x0005 is pending -> data from 0x0005 is never presented; next req addr=0x0040; inst_o=mem[0x40], pc_o=0x0041.
- branch_flag_i=1 with stall_i=1 -> no redirect; the same branch repeated after the stall clears redirects.
- rst pulled low mid-request at pc 0x0010, and separately a run from 0xFFFF -> immediate reset values and the refetch starts at RESET_PC; in the other run, the sequential fetch after 0xFFFF goes to 0x0000.
